// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus layouts and load-type encodings for the memory stage.
`include "BUS_LEN.vh"
package mem_stage_pkg;
    localparam int ES2MS_W = `ES2MS_BUS_LEN;
    localparam int MS2WS_W = `MS2WS_BUS_LEN;

    typedef enum logic [2:0] {
        LD_W  = `LD_OP_W,
        LD_B  = `LD_OP_B,
        LD_H  = `LD_OP_H,
        LD_BU = `LD_OP_BU,
        LD_HU = `LD_OP_HU
    } ld_op_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [18:0] alu_op;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic [4:0]  dest;
        logic        gr_we;
    } es2ms_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] final_result;
        logic [4:0]  dest;
        logic        gr_we;
    } ms2ws_t;
endpackage

// File: rtl/BUS_LEN.vh
// BUS_LEN: shared pipeline bus widths and load-type encodings.
`ifndef BUS_LEN_VH
`define BUS_LEN_VH
`define ES2MS_BUS_LEN 90
`define MS2WS_BUS_LEN 70
`define LD_OP_W  3'b000
`define LD_OP_B  3'b001
`define LD_OP_H  3'b010
`define LD_OP_BU 3'b101
`define LD_OP_HU 3'b110
`endif

// File: rtl/mem_stage_load_align.sv
// load_align: byte/halfword lane select with sign or zero extension.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  ld_op_e      ld_op,
    output logic [31:0] data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[8*addr +: 8];
    assign half_v = addr[1] ? rdata[31:16] : rdata[15:0];
    assign data = (ld_op == LD_B)  ? {{24{byte_v[7]}}, byte_v} :
                  (ld_op == LD_BU) ? {24'b0, byte_v} :
                  (ld_op == LD_H)  ? {{16{half_v[15]}}, half_v} :
                  (ld_op == LD_HU) ? {16'b0, half_v} : rdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; holds transient load/multiplier data across stalls.
// Sub-word load extension is enabled by defining MS_LOAD_EXT_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               ws_allowin,
    output logic               ms_allowin,
    input  logic               es2ms_valid,
    output logic               ms2ws_valid,
    input  logic [ES2MS_W-1:0] es2ms_bus,
    input  logic               es_res_from_mul,
    input  logic [2:0]         es_ld_op,
    input  logic [67:0]        mul_result,
    input  logic [31:0]        data_sram_rdata,
    output logic [MS2WS_W-1:0] ms2ws_bus,
    output logic [4:0]         mem_dest,
    output logic               mem_rf_we,
    output logic [31:0]        mem_result,
    output logic               ms_block
);
    es2ms_t      ms_bus;
    logic        ms_valid;
    logic        first_cyc;
    logic        res_from_mul;
    logic [31:0] rdata_hold;
    logic [31:0] mulw_hold;
    logic [31:0] mulw_live;
    logic [31:0] rdata_sel;
    logic [31:0] mulw_sel;
    logic [31:0] load_data;
    logic [31:0] final_result;
    logic        accept;
    logic        unused_ok;

    assign ms_allowin  = !ms_valid || ws_allowin;
    assign ms2ws_valid = ms_valid;
    assign accept      = es2ms_valid && ms_allowin;

`ifdef MS_LOAD_EXT_EN
    ld_op_e ld_op;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            ld_op <= LD_W;
        else if (accept)
            ld_op <= ld_op_e'(es_ld_op);
    end

    load_align u_load_align (
        .rdata (rdata_sel),
        .addr  (ms_bus.alu_result[1:0]),
        .ld_op (ld_op),
        .data  (load_data)
    );

    assign unused_ok = ^{mul_result[67:64], ms_bus.alu_op[18:15], ms_bus.alu_op[12:0]};
`else
    assign load_data = rdata_sel;
    assign unused_ok = ^{mul_result[67:64], ms_bus.alu_op[18:15], ms_bus.alu_op[12:0], es_ld_op};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid     <= 1'b0;
            first_cyc    <= 1'b0;
            ms_bus       <= '0;
            res_from_mul <= 1'b0;
            rdata_hold   <= '0;
            mulw_hold    <= '0;
        end else begin
            if (ms_allowin)
                ms_valid <= es2ms_valid;
            if (accept) begin
                ms_bus       <= es2ms_t'(es2ms_bus);
                res_from_mul <= es_res_from_mul;
            end
            first_cyc <= accept;
            // Live SRAM/multiplier values vanish after the first cycle; keep a copy.
            if (ms_valid && first_cyc) begin
                rdata_hold <= data_sram_rdata;
                mulw_hold  <= mulw_live;
            end
        end
    end

    assign mulw_live    = (ms_bus.alu_op[13] | ms_bus.alu_op[14]) ? mul_result[63:32] : mul_result[31:0];
    assign rdata_sel    = first_cyc ? data_sram_rdata : rdata_hold;
    assign mulw_sel     = first_cyc ? mulw_live : mulw_hold;
    assign final_result = ms_bus.res_from_mem ? load_data :
                          res_from_mul        ? mulw_sel  : ms_bus.alu_result;

    assign ms2ws_bus  = {ms_bus.pc, final_result, ms_bus.dest, ms_bus.gr_we};
    assign mem_dest   = ms_bus.dest;
    assign mem_rf_we  = ms_valid && ms_bus.gr_we;
    assign mem_result = final_result;
    assign ms_block   = ms_valid && ms_bus.res_from_mem;
endmodule
